// File: rtl/adc_cal_seq_pkg.sv
// Shared definitions for the ADC calibration sequencer: state encoding, counter
// width, parameter defaults and the state-to-output decode.
package adc_cal_seq_pkg;

    localparam int CNT_W        = 12;
    localparam int RST_LEN_DEF  = 8;
    localparam int CAL_LEN_DEF  = 4;
    localparam int BUSY_TMO_DEF = 4095;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_ADC_RST   = 3'd1;
    localparam state_t S_CAL_PULSE = 3'd2;
    localparam state_t S_WAIT_RISE = 3'd3;
    localparam state_t S_WAIT_FALL = 3'd4;
    localparam state_t S_FLUSH     = 3'd5;

    typedef struct packed {
        logic [1:0] adc_rst_b;
        logic [1:0] adc_cal;
        logic       dtu_rst_b;
        logic       dtu_flush;
        logic       seq_busy;
        logic       seq_done;
    } seq_out_t;

    localparam seq_out_t OUT_IDLE = '{
        adc_rst_b: 2'b11, adc_cal: 2'b00, dtu_rst_b: 1'b1,
        dtu_flush: 1'b0, seq_busy: 1'b0, seq_done: 1'b0
    };

    // Outputs a state presents; the caller feeds it the next state so the
    // registered outputs line up with the cycle the state is occupied.
    function automatic seq_out_t decode_outputs(input state_t st, input logic [1:0] mask);
        seq_out_t o;
        o = OUT_IDLE;
        o.seq_busy = (st != S_IDLE);
        case (st)
            S_ADC_RST: begin
                o.adc_rst_b = ~mask;
                o.dtu_rst_b = 1'b0;
            end
            S_CAL_PULSE: begin
                o.adc_cal   = mask;
                o.dtu_rst_b = 1'b0;
            end
            S_WAIT_RISE, S_WAIT_FALL: o.dtu_rst_b = 1'b0;
            S_FLUSH: begin
                o.dtu_flush = 1'b1;
                o.seq_done  = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/adc_cal_sequencer.sv
// ADC reset / calibration sequencer with registered outputs.
// Define CAL_TIMEOUT_EN to bound the busy-wait states by BUSY_TMO cycles.
module adc_cal_sequencer
    import adc_cal_seq_pkg::*;
#(
    parameter int RST_LEN  = RST_LEN_DEF,
    parameter int CAL_LEN  = CAL_LEN_DEF,
    parameter int BUSY_TMO = BUSY_TMO_DEF
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] gain_mask,
    input  logic [1:0] adc_cal_busy,
    output logic [1:0] adc_rst_b,
    output logic [1:0] adc_cal,
    output logic       dtu_rst_b,
    output logic       dtu_flush,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       tmo_err
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mask_q, mask_d;
    logic             tmo_err_q, tmo_err_d;
    seq_out_t         out_q, out_d;

    logic busy_hit;
    logic waiting;
    logic tmo_hit;

    assign busy_hit = |(adc_cal_busy & mask_q);
    assign waiting  = (state_q == S_WAIT_RISE) || (state_q == S_WAIT_FALL);
    assign tmo_hit  = (cnt_q == TMO_LAST);

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        tmo_err_d = tmo_err_q;

        case (state_q)
            S_IDLE: begin
                if (start && (gain_mask != 2'b00)) begin
                    state_d   = S_ADC_RST;
                    mask_d    = gain_mask;
                    tmo_err_d = 1'b0;
                end
            end
            S_ADC_RST:   if (cnt_q == RST_LAST) state_d = S_CAL_PULSE;
            S_CAL_PULSE: if (cnt_q == CAL_LAST) state_d = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (busy_hit) begin
                    state_d = S_WAIT_FALL;
                end
`ifdef CAL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = S_FLUSH;
                    tmo_err_d = 1'b1;
                end
`endif
            end
            S_WAIT_FALL: begin
                if (!busy_hit) begin
                    state_d = S_FLUSH;
                end
`ifdef CAL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = S_FLUSH;
                    tmo_err_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Counter restarts on every state entry and saturates in the wait
        // states so an unbounded wait cannot wrap it.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else if (waiting && tmo_hit) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        out_d = decode_outputs(state_d, mask_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mask_q    <= 2'b00;
            tmo_err_q <= 1'b0;
            out_q     <= OUT_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            tmo_err_q <= tmo_err_d;
            out_q     <= out_d;
        end
    end

    assign adc_rst_b = out_q.adc_rst_b;
    assign adc_cal   = out_q.adc_cal;
    assign dtu_rst_b = out_q.dtu_rst_b;
    assign dtu_flush = out_q.dtu_flush;
    assign seq_busy  = out_q.seq_busy;
    assign seq_done  = out_q.seq_done;
`ifdef CAL_TIMEOUT_EN
    assign tmo_err   = tmo_err_q;
`else
    assign tmo_err   = 1'b0;
`endif

endmodule
